// File: rtl/i2s_codec_slave.sv
// i2s_codec_slave: oversampled I2S slave that deserialises DAC words and serialises ADC words
module i2s_codec_slave #(
  parameter int DATA_WIDTH = 16,
  parameter int MIN_CLK_PER_PHASE = 3
) (
  input  logic                  iCLK_18_4,
  input  logic                  iRST,
  input  logic                  iAUD_BCLK,
  input  logic                  iAUD_LRCK,
  input  logic                  iAUD_DACDAT,
  output logic                  oAUD_ADCDAT,
  input  logic [DATA_WIDTH-1:0] iADC_L,
  input  logic [DATA_WIDTH-1:0] iADC_R,
  output logic [DATA_WIDTH-1:0] oDAC_L,
  output logic [DATA_WIDTH-1:0] oDAC_R,
  output logic                  oDAC_VALID,
  output logic                  oLOCKED,
  output logic                  oFRAME_ERR
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic {HUNT, LOCKED} stateT;
  stateT state, nextState;
  logic [2:0] bclkSync;
  logic [1:0] lrckSync, datSync;
  logic primed, prevLrck, haveLeft;
  logic [CW-1:0] bitCnt;
  logic [DATA_WIDTH-2:0] rxSr;
  logic [DATA_WIDTH-1:0] txSr, holdL, word;
  logic [2:0] phaseCnt;
  logic rise, fall, lrck, dat, lrckChg, shortHalf, locked;
  assign rise = bclkSync[1] & ~bclkSync[2];
  assign fall = ~bclkSync[1] & bclkSync[2];
  assign lrck = lrckSync[1];
  assign dat = datSync[1];
  // the very first rise after reset only records LRCK, so a mid-half reset release cannot fake an edge
  assign lrckChg = rise & primed & (lrck != prevLrck);
  assign shortHalf = bitCnt < FULL;
  assign word = {rxSr, dat};
  assign locked = state == LOCKED;
  always_ff @(posedge iCLK_18_4 or posedge iRST)
    if (iRST) begin
      bclkSync <= '0;
      lrckSync <= '0;
      datSync <= '0;
    end else begin
      bclkSync <= {bclkSync[1:0], iAUD_BCLK};
      lrckSync <= {lrckSync[0], iAUD_LRCK};
      datSync <= {datSync[0], iAUD_DACDAT};
    end
  always_ff @(posedge iCLK_18_4 or posedge iRST)
    if (iRST) state <= HUNT;
    else state <= nextState;
  always_comb nextState = (state == HUNT && lrckChg) ? LOCKED : state;
  always_comb begin
    oLOCKED = locked;
    oAUD_ADCDAT = locked & txSr[DATA_WIDTH-1];
  end
  always_ff @(posedge iCLK_18_4 or posedge iRST)
    if (iRST) begin
      primed <= 1'b0;
      prevLrck <= 1'b0;
      haveLeft <= 1'b0;
      bitCnt <= '0;
      rxSr <= '0;
      txSr <= '0;
      holdL <= '0;
      oDAC_L <= '0;
      oDAC_R <= '0;
      oDAC_VALID <= 1'b0;
      oFRAME_ERR <= 1'b0;
    end else begin
      oDAC_VALID <= 1'b0;
      oFRAME_ERR <= 1'b0;
      if (rise) begin
        primed <= 1'b1;
        prevLrck <= lrck;
      end
      if (lrckChg) begin
        bitCnt <= CW'(1);
        rxSr <= (DATA_WIDTH-1)'(dat);
        txSr <= txSr << 1;
        oFRAME_ERR <= locked && shortHalf;
        if (locked && shortHalf) haveLeft <= 1'b0;
      end else if (rise && locked && shortHalf) begin
        bitCnt <= bitCnt + 1'b1;
        rxSr <= word[DATA_WIDTH-2:0];
        txSr <= (bitCnt == LAST) ? (lrck ? iADC_R : iADC_L) : txSr << 1;
        if (bitCnt == LAST && lrck) begin
          holdL <= word;
          haveLeft <= 1'b1;
        end
        // a right word only completes a pair if its left partner arrived in the same frame
        if (bitCnt == LAST && !lrck && haveLeft) begin
          oDAC_L <= holdL;
          oDAC_R <= word;
          oDAC_VALID <= 1'b1;
          haveLeft <= 1'b0;
        end
      end
    end
  always_ff @(posedge iCLK_18_4 or posedge iRST)
    if (iRST) phaseCnt <= '0;
    else begin
      phaseCnt <= (rise | fall) ? 3'd1 : (phaseCnt == 3'd0 || phaseCnt == 3'd7) ? phaseCnt : phaseCnt + 3'd1;
      if ((rise | fall) && phaseCnt != 3'd0) assert (int'(phaseCnt) >= MIN_CLK_PER_PHASE - 1);
    end
endmodule

// File: tb/tb_i2s_codec_slave.sv
// tb_i2s_codec_slave: directed I2S master model checking DAC capture, ADC serialisation, framing errors and reset
`timescale 1ns/1ps
module tb_i2s_codec_slave;
  logic iCLK_18_4 = 1'b0;
  logic iRST, iAUD_BCLK, iAUD_LRCK, iAUD_DACDAT, oAUD_ADCDAT;
  logic [15:0] iADC_L, iADC_R, oDAC_L, oDAC_R;
  logic oDAC_VALID, oLOCKED, oFRAME_ERR;
  int nChecks = 0, nFails = 0, validCnt = 0, ferrCnt = 0, sinceRise = 0;
  logic timingOn = 1'b0, bPrev = 1'b0, adcPrev = 1'b0;

  i2s_codec_slave dut (
    .iCLK_18_4(iCLK_18_4), .iRST(iRST), .iAUD_BCLK(iAUD_BCLK), .iAUD_LRCK(iAUD_LRCK),
    .iAUD_DACDAT(iAUD_DACDAT), .oAUD_ADCDAT(oAUD_ADCDAT), .iADC_L(iADC_L), .iADC_R(iADC_R),
    .oDAC_L(oDAC_L), .oDAC_R(oDAC_R), .oDAC_VALID(oDAC_VALID), .oLOCKED(oLOCKED), .oFRAME_ERR(oFRAME_ERR)
  );

  always #27 iCLK_18_4 = ~iCLK_18_4;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // pulse counters and ADCDAT timing relative to each BCLK rise (posedges since the rise)
  always @(posedge iCLK_18_4) begin
    #1;
    if (oDAC_VALID === 1'b1) validCnt++;
    if (oFRAME_ERR === 1'b1) ferrCnt++;
    if (iAUD_BCLK && !bPrev) sinceRise = 1;
    else sinceRise++;
    bPrev = iAUD_BCLK;
    if (timingOn && oAUD_ADCDAT !== adcPrev) checkVal("adc_timing", sinceRise, 3);
    adcPrev = oAUD_ADCDAT;
  end

  task automatic bitCycle(input logic l, input logic d, output logic a);
    iAUD_BCLK = 1'b0;
    iAUD_LRCK = l;
    iAUD_DACDAT = d;
    repeat (3) @(negedge iCLK_18_4);
    a = oAUD_ADCDAT;
    iAUD_BCLK = 1'b1;
    repeat (3) @(negedge iCLK_18_4);
  endtask

  task automatic sendHalf(input logic l, input logic [15:0] w, input int n,
                          output logic [15:0] rx, output logic padV, output logic padStable);
    logic a, d;
    rx = '0;
    padV = 1'b0;
    padStable = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = ~w[0];
      if (i < 16) d = w[4'(15 - i)];
      bitCycle(l, d, a);
      if (i < 16) rx[4'(15 - i)] = a;
      else if (i == 16) padV = a;
      else if (a !== padV) padStable = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [15:0] l, input logic [15:0] r, input int n,
                           output logic [15:0] rxL, output logic [15:0] rxR);
    logic pv, ps;
    sendHalf(1'b1, l, n, rxL, pv, ps);
    sendHalf(1'b0, r, n, rxR, pv, ps);
  endtask

  initial begin
    logic [15:0] rl, rr;
    logic a, pv, ps;
    int v0, f0;
    iRST = 1'b1;
    iAUD_BCLK = 1'b0;
    iAUD_LRCK = 1'b0;
    iAUD_DACDAT = 1'b0;
    iADC_L = 16'h8001;
    iADC_R = 16'h1234;
    repeat (3) @(negedge iCLK_18_4);
    checkVal("rst_adcdat", oAUD_ADCDAT, 0);
    checkVal("rst_dac_l", oDAC_L, 0);
    checkVal("rst_dac_r", oDAC_R, 0);
    checkVal("rst_valid", oDAC_VALID, 0);
    checkVal("rst_locked", oLOCKED, 0);
    checkVal("rst_ferr", oFRAME_ERR, 0);
    // reset released in the middle of a right half-frame
    for (int i = 0; i < 4; i++) bitCycle(1'b0, 1'b1, a);
    iRST = 1'b0;
    for (int i = 0; i < 12; i++) bitCycle(1'b0, 1'b1, a);
    checkVal("hunt_locked", oLOCKED, 0);
    checkVal("hunt_adcdat", oAUD_ADCDAT, 0);
    sendHalf(1'b1, 16'h6000, 16, rl, pv, ps);
    checkVal("lock_locked", oLOCKED, 1);
    checkVal("lock_no_partial", validCnt, 0);
    checkVal("f1_adc_l_zero", rl, 16'h0000);
    sendHalf(1'b0, 16'hA000, 16, rr, pv, ps);
    checkVal("f1_valid_cnt", validCnt, 1);
    checkVal("f1_dac_l", oDAC_L, 16'h6000);
    checkVal("f1_dac_r", oDAC_R, 16'hA000);
    checkVal("f1_adc_r", rr, 16'h1234);
    timingOn = 1'b1;
    sendFrame(16'h6000, 16'hA000, 16, rl, rr);
    checkVal("f2_adc_l", rl, 16'h8001);
    checkVal("f2_adc_r", rr, 16'h1234);
    checkVal("f2_valid_cnt", validCnt, 2);
    checkVal("f2_ferr_cnt", ferrCnt, 0);
    // 32 BCLK per half with inverted padding bits that must be ignored
    sendHalf(1'b1, 16'hFFFF, 32, rl, pv, ps);
    checkVal("p1_adc_l", rl, 16'h8001);
    checkVal("p1_pad_l_val", pv, 0);
    checkVal("p1_pad_l_stable", ps, 1);
    sendHalf(1'b0, 16'h0000, 32, rr, pv, ps);
    checkVal("p1_adc_r", rr, 16'h1234);
    checkVal("p1_pad_r_val", pv, 1);
    checkVal("p1_pad_r_stable", ps, 1);
    checkVal("p1_dac_l", oDAC_L, 16'hFFFF);
    checkVal("p1_dac_r", oDAC_R, 16'h0000);
    sendFrame(16'h0000, 16'hFFFF, 32, rl, rr);
    checkVal("p2_dac_l", oDAC_L, 16'h0000);
    checkVal("p2_dac_r", oDAC_R, 16'hFFFF);
    checkVal("p2_valid_cnt", validCnt, 4);
    checkVal("p2_ferr_cnt", ferrCnt, 0);
    // truncated right half-frame
    v0 = validCnt;
    f0 = ferrCnt;
    sendHalf(1'b1, 16'h1357, 16, rl, pv, ps);
    sendHalf(1'b0, 16'h2468, 10, rr, pv, ps);
    checkVal("short_no_valid", validCnt - v0, 0);
    checkVal("short_no_err_yet", ferrCnt - f0, 0);
    checkVal("short_dac_l_held", oDAC_L, 16'h0000);
    sendFrame(16'hABCD, 16'h4321, 16, rl, rr);
    checkVal("short_ferr_pulse", ferrCnt - f0, 1);
    checkVal("short_next_valid", validCnt - v0, 1);
    checkVal("short_next_dac_l", oDAC_L, 16'hABCD);
    checkVal("short_next_dac_r", oDAC_R, 16'h4321);
    checkVal("short_next_adc_r", rr, 16'h1234);
    // reset asserted during a right half-frame
    timingOn = 1'b0;
    sendHalf(1'b1, 16'h1111, 16, rl, pv, ps);
    for (int i = 0; i < 6; i++) bitCycle(1'b0, 1'b1, a);
    iRST = 1'b1;
    #1;
    checkVal("mid_rst_adcdat", oAUD_ADCDAT, 0);
    checkVal("mid_rst_dac_l", oDAC_L, 0);
    checkVal("mid_rst_dac_r", oDAC_R, 0);
    checkVal("mid_rst_valid", oDAC_VALID, 0);
    checkVal("mid_rst_locked", oLOCKED, 0);
    checkVal("mid_rst_ferr", oFRAME_ERR, 0);
    for (int i = 0; i < 3; i++) bitCycle(1'b0, 1'b1, a);
    iRST = 1'b0;
    for (int i = 0; i < 7; i++) bitCycle(1'b0, 1'b1, a);
    checkVal("relock_hunt", oLOCKED, 0);
    v0 = validCnt;
    sendFrame(16'h5A5A, 16'hC3C3, 16, rl, rr);
    checkVal("relock_locked", oLOCKED, 1);
    checkVal("relock_valid", validCnt - v0, 1);
    checkVal("relock_dac_l", oDAC_L, 16'h5A5A);
    checkVal("relock_dac_r", oDAC_R, 16'hC3C3);
    checkVal("relock_adc_l_zero", rl, 16'h0000);
    checkVal("relock_adc_r", rr, 16'h1234);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
